buceros_seg_ctrl: RTL and testbench

//   Memory-mapped controller for the board's 4-digit multiplexed seven-segment display.

---
 rtl/buceros_seg_pkg.sv | 50 +++++
 rtl/buceros_seg_if.sv | 33 +++
 rtl/buceros_seg_decoder.sv | 42 ++++
 rtl/buceros_seg_ctrl.sv | 131 +++++++++++++
 tb/tb_buceros_seg_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/buceros_seg_pkg.sv
// ---------------------------------------------------------------------------
// buceros_seg_pkg
//   Shared definitions for the seven-segment display controller: register
//   offsets, CTRL field positions, idle pin levels, the bus FSM state type
//   and helpers that pack/unpack the CTRL register.
// ---------------------------------------------------------------------------
package buceros_seg_pkg;

    // Register offsets, decoded from addr[3:2]
    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_CTRL = 2'd1;

    // CTRL bit positions
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_DP_LSB    = 4;
    localparam int CTRL_BLANK_LSB = 8;

    // Pin levels that light nothing (both buses are active-low)
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] SEL_OFF = 4'hF;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_RSP  = 1'b1
    } bus_state_e;

    typedef struct packed {
        logic [3:0] blank;
        logic [3:0] dp;
        logic       en;
    } ctrl_t;

    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN_BIT]             = c.en;
        w[CTRL_DP_LSB +: 4]        = c.dp;
        w[CTRL_BLANK_LSB +: 4]     = c.blank;
        return w;
    endfunction

    function automatic ctrl_t word_to_ctrl(input logic [31:0] w);
        ctrl_t c;
        c.en    = w[CTRL_EN_BIT];
        c.dp    = w[CTRL_DP_LSB +: 4];
        c.blank = w[CTRL_BLANK_LSB +: 4];
        return c;
    endfunction

endpackage

// File: rtl/buceros_seg_if.sv
// ---------------------------------------------------------------------------
// buceros_seg_if
//   Peripheral-bus request/response channel of the display controller.
//   master : bus side (CPU / interconnect) issuing requests
//   slave  : the controller answering them
//   Signals:
//     bus_req_valid/ready  request handshake
//     bus_req_we           1=write, 0=read
//     bus_req_addr         byte offset, [3:2] selects the register
//     bus_req_wdata        write data
//     bus_rsp_valid/ready  response handshake
//     bus_rsp_rdata        read data (0 for writes)
// ---------------------------------------------------------------------------
interface buceros_seg_if;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_req_we;
    logic [3:0]  bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic        bus_rsp_valid;
    logic        bus_rsp_ready;
    logic [31:0] bus_rsp_rdata;

    modport master (
        output bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_rsp_ready,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata
    );

    modport slave (
        input  bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_rsp_ready,
        output bus_req_ready, bus_rsp_valid, bus_rsp_rdata
    );
endinterface

// File: rtl/buceros_seg_decoder.sv
// ---------------------------------------------------------------------------
// buceros_seg_decoder
//   Combinational hex-nibble to seven-segment code, active-low.
//   Ports:
//     hex    in  4  nibble to display
//     dp_on  in  1  light the decimal point
//     seg    out 8  [0]=a .. [6]=g, [7]=dp, all active-low
// ---------------------------------------------------------------------------
module buceros_seg_decoder
    import buceros_seg_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp_on,
    output logic [7:0] seg
);

    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        seg = SEG_OFF;
        case (hex)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
        endcase
        seg[7] = ~dp_on;
    end

endmodule

// File: rtl/buceros_seg_ctrl.sv
// ---------------------------------------------------------------------------
// buceros_seg_ctrl
//   Memory-mapped controller for a 4-digit multiplexed seven-segment display.
//   Holds DATA (four hex nibbles) and CTRL (enable, dp mask, blank mask),
//   answers one outstanding bus request at a time and scans the digits,
//   each for SCAN_DIV clock cycles.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     bus         buceros_seg_if.slave request/response channel
//     seg         segments, active-low, [7]=dp
//     seg_sel     digit enables, active-low one-hot, [0]=rightmost
// ---------------------------------------------------------------------------
module buceros_seg_ctrl
    import buceros_seg_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    buceros_seg_if.slave      bus,
    output logic [7:0]        seg,
    output logic [3:0]        seg_sel
);

    localparam int                 PRESC_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);

    bus_state_e        state_q;
    logic [31:0]       rdata_q;
    logic [15:0]       data_q;
    ctrl_t             ctrl_q;
    logic [PRESC_W-1:0] presc_q;
    logic [1:0]        digit_q;

    logic              req_fire;
    logic [31:0]       rd_word;
    logic [3:0]        cur_nibble;
    logic [7:0]        dec_seg;
    logic [7:0]        seg_d;
    logic [3:0]        sel_d;

    // ------------------------------------------------------------------
    // Bus side: a new request can be taken whenever the response slot is
    // empty or is being drained this very cycle (no bubble).
    // ------------------------------------------------------------------
    assign bus.bus_req_ready = (state_q == BUS_IDLE) | bus.bus_rsp_ready;
    assign bus.bus_rsp_valid = (state_q == BUS_RSP);
    assign bus.bus_rsp_rdata = rdata_q;
    assign req_fire          = bus.bus_req_valid & bus.bus_req_ready;

    always_comb begin
        rd_word = '0;
        case (bus.bus_req_addr[3:2])
            REG_DATA: rd_word = {16'h0000, data_q};
            REG_CTRL: rd_word = ctrl_to_word(ctrl_q);
            default:  rd_word = '0;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUS_IDLE;
            rdata_q <= '0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else if (req_fire) begin
            state_q <= BUS_RSP;
            rdata_q <= bus.bus_req_we ? 32'h0 : rd_word;
            if (bus.bus_req_we) begin
                case (bus.bus_req_addr[3:2])
                    REG_DATA: data_q <= bus.bus_req_wdata[15:0];
                    REG_CTRL: ctrl_q <= word_to_ctrl(bus.bus_req_wdata);
                    default:  ;
                endcase
            end
        end else if (bus.bus_rsp_ready) begin
            state_q <= BUS_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Scan timing: prescaler and digit index free-run even while the
    // display is disabled, so re-enabling never restarts the scan phase.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            digit_q <= '0;
        end else if (presc_q == PRESC_MAX) begin
            presc_q <= '0;
            digit_q <= digit_q + 2'd1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pin drive: recomputed every cycle, so a register write shows up one
    // cycle after it lands. A blanked or disabled slot turns the digit
    // select off too, so nothing ghosts onto the neighbour digit.
    // ------------------------------------------------------------------
    assign cur_nibble = data_q[{digit_q, 2'b00} +: 4];

    buceros_seg_decoder u_decoder (
        .hex   (cur_nibble),
        .dp_on (ctrl_q.dp[digit_q]),
        .seg   (dec_seg)
    );

    always_comb begin
        seg_d = SEG_OFF;
        sel_d = SEL_OFF;
        if (ctrl_q.en && !ctrl_q.blank[digit_q]) begin
            seg_d = dec_seg;
            sel_d = ~(4'b0001 << digit_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg     <= SEG_OFF;
            seg_sel <= SEL_OFF;
        end else begin
            seg     <= seg_d;
            seg_sel <= sel_d;
        end
    end

endmodule

// File: tb/tb_buceros_seg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_buceros_seg_ctrl
//   Self-checking bench for buceros_seg_ctrl with SCAN_DIV=4. Bus responses
//   are checked through a scoreboard queue; display pins against fixed
//   expected patterns.
// ---------------------------------------------------------------------------
module tb_buceros_seg_ctrl;

    localparam int SCAN_DIV = 4;

    typedef struct {
        logic [31:0] rdata;
        bit          chk;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [7:0] seg;
    logic [3:0] seg_sel;

    int tests_run;
    int tests_failed;
    exp_t sb[$];

    buceros_seg_if bus_if ();

    buceros_seg_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus_if.slave),
        .seg     (seg),
        .seg_sel (seg_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    // Issue one request with rsp_ready held high; called and returns at a
    // negedge. The expected response is queued when the request is driven
    // and popped when the response shows up.
    task automatic bus_txn(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input string name);
        exp_t e;
        exp_t got;
        int   k;
        bus_if.bus_req_valid = 1'b1;
        bus_if.bus_req_we    = we;
        bus_if.bus_req_addr  = addr;
        bus_if.bus_req_wdata = wdata;
        bus_if.bus_rsp_ready = 1'b1;
        e.rdata = exp_rdata;
        e.chk   = !we;
        sb.push_back(e);
        #1;
        k = 0;
        while (!bus_if.bus_req_ready && k < 16) begin
            @(negedge clk);
            #1;
            k++;
        end
        @(posedge clk);
        @(negedge clk);
        bus_if.bus_req_valid = 1'b0;
        k = 0;
        while (!bus_if.bus_rsp_valid && k < 16) begin
            @(negedge clk);
            k++;
        end
        got = sb.pop_front();
        tests_run++;
        if (bus_if.bus_rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s: no response, rsp_valid=%b required 1", name, bus_if.bus_rsp_valid);
        end else if (got.chk && bus_if.bus_rsp_rdata !== got.rdata) begin
            tests_failed++;
            $display("FAIL %s: rdata=%h required %h", name, bus_if.bus_rsp_rdata, got.rdata);
        end
    endtask

    // Sync to the first cycle of digit 0's slot, then check all four slots
    // cycle by cycle (SCAN_DIV cycles each) and the wrap back to digit 0.
    task automatic check_scan(input logic [15:0] esel, input logic [31:0] eseg, input string name);
        logic [3:0] prev;
        bit         found;
        logic [3:0] xs;
        logic [7:0] xg;
        prev  = seg_sel;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (seg_sel === 4'hE && prev !== 4'hE) begin
                found = 1;
                break;
            end
            prev = seg_sel;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL %s sync: digit-0 slot never started, seg_sel=%h required E", name, seg_sel);
            return;
        end
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < SCAN_DIV; c++) begin
                if (s != 0 || c != 0) @(negedge clk);
                xs = esel[4*s +: 4];
                xg = eseg[8*s +: 8];
                tests_run++;
                if ({seg_sel, seg} !== {xs, xg}) begin
                    tests_failed++;
                    $display("FAIL %s digit%0d cyc%0d: sel/seg=%h/%h required %h/%h",
                             name, s, c, seg_sel, seg, xs, xg);
                end
            end
        end
        @(negedge clk);
        xs = esel[3:0];
        xg = eseg[7:0];
        tests_run++;
        if ({seg_sel, seg} !== {xs, xg}) begin
            tests_failed++;
            $display("FAIL %s wrap: sel/seg=%h/%h required %h/%h", name, seg_sel, seg, xs, xg);
        end
    endtask

    task automatic check_pins(input logic [3:0] xs, input logic [7:0] xg, input string name);
        tests_run++;
        if ({seg_sel, seg} !== {xs, xg}) begin
            tests_failed++;
            $display("FAIL %s: sel/seg=%h/%h required %h/%h", name, seg_sel, seg, xs, xg);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.bus_rsp_ready = 1'b0;
        #12;
        check_pins(4'hF, 8'hFF, "reset pins");
        tests_run++;
        if (bus_if.bus_rsp_valid !== 1'b0 || bus_if.bus_req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset handshake: rsp_valid=%b req_ready=%b required 0/1",
                     bus_if.bus_rsp_valid, bus_if.bus_req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_txn(1'b0, 4'h0, 32'h0, 32'h0, "reset read DATA");
        bus_txn(1'b0, 4'h4, 32'h0, 32'h0, "reset read CTRL");
    endtask

    task automatic test_hex_scan();
        bus_txn(1'b1, 4'h0, 32'h0000_12AF, 32'h0, "write DATA 12AF");
        check_pins(4'hF, 8'hFF, "disabled before enable");
        bus_txn(1'b1, 4'h4, 32'h0000_0001, 32'h0, "write CTRL 001");
        check_scan({4'h7, 4'hB, 4'hD, 4'hE}, {8'hF9, 8'hA4, 8'h88, 8'h8E}, "scan 12AF");
    endtask

    task automatic test_dp_blank();
        bus_txn(1'b1, 4'h4, 32'h0000_0211, 32'h0, "write CTRL 211");
        bus_txn(1'b1, 4'h0, 32'h0000_8888, 32'h0, "write DATA 8888");
        check_scan({4'h7, 4'hB, 4'hF, 4'hE}, {8'h80, 8'h80, 8'hFF, 8'h00}, "scan dp/blank");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_t got;
        bus_if.bus_rsp_ready = 1'b0;
        bus_if.bus_req_valid = 1'b1;
        bus_if.bus_req_we    = 1'b0;
        bus_if.bus_req_addr  = 4'h0;
        e.rdata = 32'h0000_8888;
        e.chk   = 1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus_if.bus_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (bus_if.bus_rsp_valid !== 1'b1 || bus_if.bus_rsp_rdata !== sb[0].rdata ||
                bus_if.bus_req_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall cyc%0d: rsp_valid=%b rdata=%h req_ready=%b required 1/%h/0",
                         i, bus_if.bus_rsp_valid, bus_if.bus_rsp_rdata, bus_if.bus_req_ready,
                         sb[0].rdata);
            end
            @(negedge clk);
        end
        // Drain the stalled response and issue the next read in the same cycle.
        bus_if.bus_rsp_ready = 1'b1;
        bus_if.bus_req_valid = 1'b1;
        bus_if.bus_req_addr  = 4'h4;
        e.rdata = 32'h0000_0211;
        sb.push_back(e);
        #1;
        tests_run++;
        if (bus_if.bus_req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL back-to-back ready: req_ready=%b required 1", bus_if.bus_req_ready);
        end
        void'(sb.pop_front());
        @(posedge clk);
        @(negedge clk);
        bus_if.bus_req_valid = 1'b0;
        got = sb.pop_front();
        tests_run++;
        if (bus_if.bus_rsp_valid !== 1'b1 || bus_if.bus_rsp_rdata !== got.rdata) begin
            tests_failed++;
            $display("FAIL back-to-back rsp: rsp_valid=%b rdata=%h required 1/%h",
                     bus_if.bus_rsp_valid, bus_if.bus_rsp_rdata, got.rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_reserved();
        bus_txn(1'b1, 4'h8, 32'h0000_FFFF, 32'h0, "reserved write 0x8");
        bus_txn(1'b0, 4'h0, 32'h0, 32'h0000_8888, "DATA after reserved write");
        bus_txn(1'b0, 4'h4, 32'h0, 32'h0000_0211, "CTRL after reserved write");
        bus_txn(1'b0, 4'h8, 32'h0, 32'h0, "reserved read 0x8");
        bus_txn(1'b0, 4'hC, 32'h0, 32'h0, "reserved read 0xC");
        bus_txn(1'b0, 4'h7, 32'h0, 32'h0000_0211, "CTRL via addr 0x7");
        bus_txn(1'b1, 4'h0, 32'hFFFF_FFFF, 32'h0, "write DATA all ones");
        bus_txn(1'b0, 4'h0, 32'h0, 32'h0000_FFFF, "DATA upper bits read 0");
        bus_txn(1'b1, 4'h4, 32'hFFFF_FFFF, 32'h0, "write CTRL all ones");
        bus_txn(1'b0, 4'h4, 32'h0, 32'h0000_0FF1, "CTRL unused bits read 0");
    endtask

    task automatic test_reset_midscan();
        bit found;
        bus_txn(1'b1, 4'h4, 32'h0000_0001, 32'h0, "enable for reset test");
        found = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (seg_sel === 4'hB) begin
                found = 1;
                break;
            end
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL reset-test sync: digit 2 never selected, seg_sel=%h", seg_sel);
        end
        @(negedge clk);
        // Leave a read response pending.
        bus_if.bus_rsp_ready = 1'b0;
        bus_if.bus_req_valid = 1'b1;
        bus_if.bus_req_we    = 1'b0;
        bus_if.bus_req_addr  = 4'h0;
        @(posedge clk);
        @(negedge clk);
        bus_if.bus_req_valid = 1'b0;
        tests_run++;
        if (bus_if.bus_rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL pending rsp: rsp_valid=%b required 1", bus_if.bus_rsp_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        check_pins(4'hF, 8'hFF, "async reset pins");
        tests_run++;
        if (bus_if.bus_rsp_valid !== 1'b0 || bus_if.bus_rsp_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL async reset rsp: rsp_valid=%b rdata=%h required 0/0",
                     bus_if.bus_rsp_valid, bus_if.bus_rsp_rdata);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus_if.bus_rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_pins(4'hF, 8'hFF, "disabled after reset");
        end
        bus_txn(1'b0, 4'h4, 32'h0, 32'h0, "CTRL after reset");
        // Second reset, then enable right at release: digit 0 must own the
        // first full slot, proving prescaler and index restarted from 0.
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus_txn(1'b1, 4'h4, 32'h0000_0001, 32'h0, "enable at release");
        check_pins(4'hF, 8'hFF, "pins before enable visible");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_pins(4'hE, 8'hC0, "restart digit 0");
        end
        @(negedge clk);
        check_pins(4'hD, 8'hC0, "restart digit 1");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n                = 1'b0;
        bus_if.bus_req_valid = 1'b0;
        bus_if.bus_req_we    = 1'b0;
        bus_if.bus_req_addr  = 4'h0;
        bus_if.bus_req_wdata = 32'h0;
        bus_if.bus_rsp_ready = 1'b0;

        test_reset();
        test_hex_scan();
        test_dp_blank();
        test_back_to_back();
        test_reserved();
        test_reset_midscan();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
